// File: rtl/noc_pkg.sv
`default_nettype none
// ============================================================================
// noc_pkg: types and default sizes shared by the router input-port logic.
// Revision: 1.0
// ============================================================================
package noc_pkg;

  localparam int unsigned c_DEFAULT_DATA_WIDTH = 32;
  localparam int unsigned c_DEFAULT_DEPTH      = 4;

  typedef logic [c_DEFAULT_DATA_WIDTH-1:0] flit_t;

  typedef enum logic [0:0] {
    CTS_IDLE = 1'b0,
    CTS_ACK  = 1'b1
  } cts_state_t;

endpackage
`default_nettype wire

// File: rtl/flit_input_fifo_storage.sv
`default_nettype none
// ============================================================================
// fifo_storage: register-array FIFO with wrapping pointers and an occupancy
// count; the head entry is read combinationally.
// Revision: 1.0
// ============================================================================
module fifo_storage
  import noc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = c_DEFAULT_DATA_WIDTH,
  parameter int unsigned DEPTH      = c_DEFAULT_DEPTH,
  localparam int unsigned PTR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  full,
  output logic [PTR_W:0]        count
);

  localparam logic [PTR_W:0] c_FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [PTR_W:0]        r_count;
  logic                  w_rd_fire;

  // A pop against an empty FIFO is dropped entirely.
  assign w_rd_fire = rd_en && (r_count != '0);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (wr_en) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd_fire) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({wr_en, w_rd_fire})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign rd_data = r_mem[r_rd_ptr];
  assign empty   = (r_count == '0);
  assign full    = (r_count == c_FULL_CNT);
  assign count   = r_count;

endmodule
`default_nettype wire

// File: rtl/flit_input_fifo.sv
`default_nettype none
// ============================================================================
// flit_input_fifo: downstream side of the RTS/CTS link; buffers each offered
// flit and answers it with a single-cycle CTS.
// Revision: 1.0
// ============================================================================
module flit_input_fifo
  import noc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = c_DEFAULT_DATA_WIDTH,
  parameter int unsigned DEPTH      = c_DEFAULT_DEPTH,
  localparam int unsigned PTR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] RX,
  input  logic                  DRTS,
  output logic                  CTS,
  input  logic                  read_en,
  output logic [DATA_WIDTH-1:0] Data_out,
  output logic                  empty,
  output logic                  full,
  output logic [PTR_W:0]        count
);

  localparam logic [0:0] c_ST_IDLE = CTS_IDLE;
  localparam logic [0:0] c_ST_ACK  = CTS_ACK;

  logic [0:0] r_state;
  logic       w_full;
  logic       w_wr_en;

  // Capture only from IDLE: the ACK cycle still sees the old RTS, which must
  // not be written a second time.
  assign w_wr_en = (r_state == c_ST_IDLE) && DRTS && !w_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_ST_IDLE;
    end else if (w_wr_en) begin
      r_state <= c_ST_ACK;
    end else begin
      r_state <= c_ST_IDLE;
    end
  end

  assign CTS  = (r_state == c_ST_ACK);
  assign full = w_full;

  fifo_storage #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_storage (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (w_wr_en),
    .wr_data (RX),
    .rd_en   (read_en),
    .rd_data (Data_out),
    .empty   (empty),
    .full    (w_full),
    .count   (count)
  );

endmodule
`default_nettype wire
